// File: rtl/adc_log_sequencer_pkg.sv
// Shared encodings for the die-temperature logging sequencer.
// Contains the FSM states, the FILL/DRAIN mode values, the timeout code and the offset clamp.
package adc_log_sequencer_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_ARMED = 2'd1,
        DRAIN      = 2'd2
    } seq_state_t;

    localparam logic        MODE_FILL    = 1'b0;
    localparam logic        MODE_DRAIN   = 1'b1;
    localparam logic [11:0] TIMEOUT_CODE = 12'hFFF;

    // Raw codes below the offset clamp to zero instead of wrapping.
    function automatic logic [11:0] offset_correct(input logic [11:0] raw, input logic [11:0] offset);
        return (raw < offset) ? 12'd0 : raw - offset;
    endfunction

endpackage

// File: rtl/adc_log_sequencer_if.sv
// Bundle of the ADC response, control pulses and FIFO-side signals of the logging sequencer.
// The slave modport is the sequencer's view; the master modport drives the inputs and observes the outputs.
interface adc_log_sequencer_if;
    logic        sample_tick;
    logic        step;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        fifo_wrreq;
    logic [11:0] fifo_data;
    logic        fifo_rdreq;
    logic        mode;
    logic [4:0]  level;
    logic        timeout_err;
    logic [7:0]  missed_ticks;
    logic        capture_blip;

    modport slave (
        input  sample_tick, step, response_valid, response_channel, response_data,
        output fifo_wrreq, fifo_data, fifo_rdreq, mode, level, timeout_err, missed_ticks, capture_blip
    );

    modport master (
        output sample_tick, step, response_valid, response_channel, response_data,
        input  fifo_wrreq, fifo_data, fifo_rdreq, mode, level, timeout_err, missed_ticks, capture_blip
    );
endinterface

// File: rtl/adc_log_sequencer_capture.sv
// Capture datapath: arm timer, channel match, offset correction and timeout code insertion.
// Write strobe and data are registered one clock after the accepting cycle; there is no backpressure.
module adc_capture_unit
    import adc_log_sequencer_pkg::*;
#(
    parameter int OFFSET  = 3431,
    parameter int CHANNEL = 17,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        armed_i,
    input  logic        resp_vld_i,
    input  logic [4:0]  resp_chan_i,
    input  logic [11:0] resp_dat_i,
    output logic        hit_o,
    output logic        tmo_o,
    output logic        wrreq_o,
    output logic [11:0] data_o,
    output logic        timeout_err_o,
    output logic        blip_o
);
    localparam int           TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);
    localparam logic [4:0]   CHANNEL_L = 5'(CHANNEL);
    localparam logic [11:0]  OFFSET_L  = 12'(OFFSET);

    logic [TW-1:0] timer_q, timer_d;
    logic          wrreq_q, wrreq_d;
    logic [11:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          blip_q, blip_d;

    // A matching response in the final timer cycle still counts as a capture.
    assign hit_o = armed_i && resp_vld_i && (resp_chan_i == CHANNEL_L);
    assign tmo_o = armed_i && !hit_o && (timer_q == TIMEOUT_L);

    always_comb begin
        timer_d = armed_i ? timer_q + 1'b1 : '0;
        wrreq_d = hit_o || tmo_o;
        data_d  = data_q;
        if (hit_o)
            data_d = offset_correct(resp_dat_i, OFFSET_L);
        else if (tmo_o)
            data_d = TIMEOUT_CODE;
        err_d  = err_q || tmo_o;
        blip_d = blip_q ^ wrreq_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            wrreq_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            blip_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
            err_q   <= err_d;
            blip_q  <= blip_d;
        end
    end

    assign wrreq_o       = wrreq_q;
    assign data_o        = data_q;
    assign timeout_err_o = err_q;
    assign blip_o        = blip_q;
endmodule

// File: rtl/adc_log_sequencer.sv
// FILL/DRAIN sequencer between the ADC response stream and a 32-word FIFO; owns level, mode, reads, missed ticks.
// Write and read strobes are registered one clock after the accepting cycle; there is no backpressure.
module adc_log_sequencer
    import adc_log_sequencer_pkg::*;
#(
    parameter int LIMIT   = 30,
    parameter int OFFSET  = 3431,
    parameter int CHANNEL = 17,
    parameter int TIMEOUT = 1023
) (
    input logic               clock_in,
    input logic               aclr,
    adc_log_sequencer_if.slave bus
);
    localparam logic [4:0] LIMIT_L = 5'(LIMIT);

    seq_state_t  state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic        rdreq_q, rdreq_d;
    logic [7:0]  missed_q, missed_d;
    logic        armed, hit, tmo, wrreq, rd_fire;

    adc_capture_unit #(
        .OFFSET (OFFSET),
        .CHANNEL(CHANNEL),
        .TIMEOUT(TIMEOUT)
    ) u_capture (
        .clk          (clock_in),
        .rst          (aclr),
        .armed_i      (armed),
        .resp_vld_i   (bus.response_valid),
        .resp_chan_i  (bus.response_channel),
        .resp_dat_i   (bus.response_data),
        .hit_o        (hit),
        .tmo_o        (tmo),
        .wrreq_o      (wrreq),
        .data_o       (bus.fifo_data),
        .timeout_err_o(bus.timeout_err),
        .blip_o       (bus.capture_blip)
    );

    always_ff @(posedge clock_in or posedge aclr) begin
        if (aclr) state_q <= FILL_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL_IDLE:  if (bus.sample_tick) state_d = FILL_ARMED;
            FILL_ARMED: if (hit || tmo)      state_d = FILL_IDLE;
            DRAIN:      if (rdreq_q && level_q == 5'd0) state_d = FILL_IDLE;
            default:    state_d = FILL_IDLE;
        endcase
        // The LIMIT-th write strobe overrides any arm requested in the same cycle.
        if (state_q != DRAIN && wrreq && level_q == LIMIT_L)
            state_d = DRAIN;
    end

    always_comb begin
        armed    = (state_q == FILL_ARMED);
        bus.mode = (state_q == DRAIN) ? MODE_DRAIN : MODE_FILL;
    end

    assign rd_fire = (state_q == DRAIN) && bus.step && (level_q != 5'd0);

    always_comb begin
        rdreq_d  = rd_fire;
        level_d  = level_q;
        if (hit || tmo)
            level_d = level_q + 5'd1;
        else if (rd_fire)
            level_d = level_q - 5'd1;
        missed_d = missed_q;
        if (armed && bus.sample_tick && missed_q != 8'hFF)
            missed_d = missed_q + 8'd1;
    end

    always_ff @(posedge clock_in or posedge aclr) begin
        if (aclr) begin
            level_q  <= '0;
            rdreq_q  <= 1'b0;
            missed_q <= '0;
        end else begin
            level_q  <= level_d;
            rdreq_q  <= rdreq_d;
            missed_q <= missed_d;
        end
    end

    assign bus.fifo_wrreq   = wrreq;
    assign bus.fifo_rdreq   = rdreq_q;
    assign bus.level        = level_q;
    assign bus.missed_ticks = missed_q;
endmodule
